// File: rtl/nasti_lite_read_arbiter.sv
// Round-robin arbiter sharing one nasti-lite read port (AR/R) among N_MASTER requesters.
// The requester index rides in the top bits of the downstream ID and routes R beats back.
module nasti_lite_read_arbiter #(
  parameter int unsigned N_MASTER        = 2,
  parameter int unsigned ID_WIDTH        = 1,
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned IDX_BITS       = $clog2(N_MASTER),
  localparam int unsigned MID_WIDTH      = ID_WIDTH + IDX_BITS
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [N_MASTER*ID_WIDTH-1:0]   s_ar_id,
  input  logic [N_MASTER*ADDR_WIDTH-1:0] s_ar_addr,
  input  logic [N_MASTER*3-1:0]          s_ar_prot,
  input  logic [N_MASTER-1:0]            s_ar_valid,
  output logic [N_MASTER-1:0]            s_ar_ready,
  output logic [N_MASTER*ID_WIDTH-1:0]   s_r_id,
  output logic [DATA_WIDTH-1:0]          s_r_data,
  output logic [1:0]                     s_r_resp,
  output logic [N_MASTER-1:0]            s_r_valid,
  input  logic [N_MASTER-1:0]            s_r_ready,
  output logic [MID_WIDTH-1:0]           m_ar_id,
  output logic [ADDR_WIDTH-1:0]          m_ar_addr,
  output logic [2:0]                     m_ar_prot,
  output logic                           m_ar_valid,
  input  logic                           m_ar_ready,
  input  logic [MID_WIDTH-1:0]           m_r_id,
  input  logic [DATA_WIDTH-1:0]          m_r_data,
  input  logic [1:0]                     m_r_resp,
  input  logic                           m_r_valid,
  output logic                           m_r_ready,
  output logic                           r_err
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
    $fatal(1, "nasti_lite_read_arbiter: DATA_WIDTH must be 32 or 64");
  end
  if (N_MASTER < 2) begin : g_bad_n_master
    $fatal(1, "nasti_lite_read_arbiter: N_MASTER must be at least 2");
  end

  logic [N_MASTER-1:0]   elig_c;
  logic [IDX_BITS-1:0]   sel_c;
  logic                  load_c;
  int unsigned           cand;
  logic [IDX_BITS-1:0]   rr_q, rr_d;
  logic                  m_ar_valid_q, m_ar_valid_d;
  logic [MID_WIDTH-1:0]  m_ar_id_q, m_ar_id_d;
  logic [ADDR_WIDTH-1:0] m_ar_addr_q, m_ar_addr_d;
  logic [2:0]            m_ar_prot_q, m_ar_prot_d;
  logic [CNT_W-1:0]      cnt_q [N_MASTER];
  logic [CNT_W-1:0]      cnt_d [N_MASTER];
  logic                  r_err_q, r_err_d;
  logic [IDX_BITS-1:0]   r_idx_c;
  logic                  r_idx_ok_c;
  logic                  inc_c, dec_c;

  // Round-robin pick: first eligible requester starting at rr_q.
  always_comb begin
    sel_c = '0;
    cand  = 0;
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      elig_c[i] = s_ar_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
    end
    for (int k = int'(N_MASTER) - 1; k >= 0; k--) begin
      cand = 32'(rr_q) + 32'(k);
      if (cand >= N_MASTER) cand = cand - N_MASTER;
      if (elig_c[IDX_BITS'(cand)]) sel_c = IDX_BITS'(cand);
    end
    load_c     = rstn && (!m_ar_valid_q || m_ar_ready) && (|elig_c);
    s_ar_ready = load_c ? (N_MASTER'(1) << sel_c) : '0;
  end

  always_comb begin
    m_ar_valid_d = m_ar_valid_q;
    m_ar_id_d    = m_ar_id_q;
    m_ar_addr_d  = m_ar_addr_q;
    m_ar_prot_d  = m_ar_prot_q;
    rr_d         = rr_q;
    if (load_c) begin
      m_ar_valid_d = 1'b1;
      m_ar_id_d    = {sel_c, s_ar_id[sel_c*ID_WIDTH +: ID_WIDTH]};
      m_ar_addr_d  = s_ar_addr[sel_c*ADDR_WIDTH +: ADDR_WIDTH];
      m_ar_prot_d  = s_ar_prot[sel_c*3 +: 3];
      rr_d         = (sel_c == IDX_BITS'(N_MASTER - 1)) ? '0 : sel_c + IDX_BITS'(1);
    end else if (m_ar_ready) begin
      m_ar_valid_d = 1'b0;
    end
  end

  // Zero-latency R routing; beats with an out-of-range index are sunk and flagged.
  always_comb begin
    r_idx_c    = m_r_id[MID_WIDTH-1 -: IDX_BITS];
    r_idx_ok_c = 32'(r_idx_c) < N_MASTER;
    s_r_valid  = '0;
    m_r_ready  = 1'b1;
    if (r_idx_ok_c) begin
      s_r_valid[r_idx_c] = m_r_valid;
      m_r_ready          = s_r_ready[r_idx_c];
    end
    r_err_d = r_err_q || (m_r_valid && !r_idx_ok_c);
  end

  always_comb begin
    inc_c = 1'b0;
    dec_c = 1'b0;
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      cnt_d[i] = cnt_q[i];
      inc_c    = s_ar_ready[i];
      dec_c    = s_r_valid[i] && s_r_ready[i] && (cnt_q[i] != '0);
      if (inc_c && !dec_c)      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (dec_c && !inc_c) cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_q         <= '0;
      m_ar_valid_q <= 1'b0;
      m_ar_id_q    <= '0;
      m_ar_addr_q  <= '0;
      m_ar_prot_q  <= '0;
      r_err_q      <= 1'b0;
      for (int unsigned i = 0; i < N_MASTER; i++) cnt_q[i] <= '0;
    end else begin
      rr_q         <= rr_d;
      m_ar_valid_q <= m_ar_valid_d;
      m_ar_id_q    <= m_ar_id_d;
      m_ar_addr_q  <= m_ar_addr_d;
      m_ar_prot_q  <= m_ar_prot_d;
      r_err_q      <= r_err_d;
      for (int unsigned i = 0; i < N_MASTER; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign m_ar_valid = m_ar_valid_q;
  assign m_ar_id    = m_ar_id_q;
  assign m_ar_addr  = m_ar_addr_q;
  assign m_ar_prot  = m_ar_prot_q;
  assign r_err      = r_err_q;
  assign s_r_id     = {N_MASTER{m_r_id[ID_WIDTH-1:0]}};
  assign s_r_data   = m_r_data;
  assign s_r_resp   = m_r_resp;

endmodule
